// File: rtl/vedic_nxn_pipe.sv
// Two-stage pipelined Vedic NxN multiplier-accumulator with valid/ready handshakes.
// Stage 1 registers operand magnitudes; stage 2 combines Vedic quadrants, signs and accumulates.

module vedic_nxn_mul #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  if (N == 2) begin : g_cell
    // 2x2 Urdhva-Tiryagbhyam: vertical, crosswise, vertical.
    logic cross_c;
    assign p[0]    = a[0] & b[0];
    assign p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign cross_c = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2]    = (a[1] & b[1]) ^ cross_c;
    assign p[3]    = (a[1] & b[1]) & cross_c;
  end else begin : g_split
    logic [N-1:0]   q_ll, q_lh, q_hl, q_hh;
    logic [2*N-1:0] q_mid;

    vedic_nxn_mul #(.N(N/2)) u_ll (.a(a[N/2-1:0]), .b(b[N/2-1:0]), .p(q_ll));
    vedic_nxn_mul #(.N(N/2)) u_lh (.a(a[N/2-1:0]), .b(b[N-1:N/2]), .p(q_lh));
    vedic_nxn_mul #(.N(N/2)) u_hl (.a(a[N-1:N/2]), .b(b[N/2-1:0]), .p(q_hl));
    vedic_nxn_mul #(.N(N/2)) u_hh (.a(a[N-1:N/2]), .b(b[N-1:N/2]), .p(q_hh));

    assign q_mid = (2*N)'(q_hl) + (2*N)'(q_lh);
    // hh<<N + ll never overlap, so they concatenate.
    assign p     = {q_hh, q_ll} + (q_mid << (N/2));
  end
endmodule

module vedic_nxn_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [ACC_W-1:0]     acc,
  output logic                 acc_ovf
);
  localparam int HW = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_mag_a_q, s1_mag_a_d;
  logic [WIDTH-1:0] s1_mag_b_q, s1_mag_b_d;
  logic             s1_neg_q, s1_neg_d;
  logic             s1_sm_q, s1_sm_d;
  logic             s1_en_q, s1_en_d;
  logic             s1_clr_q, s1_clr_d;

  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    product_q, product_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic             stall;
  logic             a_neg, b_neg;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~(s1_valid_q & stall);
  assign a_neg    = signed_mode & a[WIDTH-1];
  assign b_neg    = signed_mode & b[WIDTH-1];

  // Stage 1 accepts whenever it is empty or draining into stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mag_a_d = s1_mag_a_q;
    s1_mag_b_d = s1_mag_b_q;
    s1_neg_d   = s1_neg_q;
    s1_sm_d    = s1_sm_q;
    s1_en_d    = s1_en_q;
    s1_clr_d   = s1_clr_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mag_a_d = a_neg ? (-a) : a;
        s1_mag_b_d = b_neg ? (-b) : b;
        s1_neg_d   = a_neg ^ b_neg;
        s1_sm_d    = signed_mode;
        s1_en_d    = acc_en;
        s1_clr_d   = acc_clr;
      end
    end
  end

  logic [WIDTH-1:0] q_ll, q_lh, q_hl, q_hh;

  vedic_nxn_mul #(.N(HW)) u_q_ll (.a(s1_mag_a_q[HW-1:0]),    .b(s1_mag_b_q[HW-1:0]),    .p(q_ll));
  vedic_nxn_mul #(.N(HW)) u_q_lh (.a(s1_mag_a_q[HW-1:0]),    .b(s1_mag_b_q[WIDTH-1:HW]), .p(q_lh));
  vedic_nxn_mul #(.N(HW)) u_q_hl (.a(s1_mag_a_q[WIDTH-1:HW]), .b(s1_mag_b_q[HW-1:0]),    .p(q_hl));
  vedic_nxn_mul #(.N(HW)) u_q_hh (.a(s1_mag_a_q[WIDTH-1:HW]), .b(s1_mag_b_q[WIDTH-1:HW]), .p(q_hh));

  logic [PW-1:0]    q_mid, mag_p, prod_s;
  logic [ACC_W-1:0] prod_ext, acc_base, acc_add;
  logic [ACC_W:0]   acc_sum;
  logic             add_ovf;

  always_comb begin
    q_mid    = PW'(q_hl) + PW'(q_lh);
    mag_p    = {q_hh, q_ll} + (q_mid << HW);
    // Magnitude of -2^(W-1) squared is 2^(2W-2), which still fits in PW bits.
    prod_s   = s1_neg_q ? (-mag_p) : mag_p;
    prod_ext = s1_sm_q ? ACC_W'($signed(prod_s)) : ACC_W'(prod_s);
    acc_base = s1_clr_q ? '0 : acc_q;
    acc_add  = s1_en_q ? prod_ext : '0;
    acc_sum  = {1'b0, acc_base} + {1'b0, acc_add};
    if (s1_sm_q)
      add_ovf = (acc_base[ACC_W-1] == acc_add[ACC_W-1]) &&
                (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
    else
      add_ovf = acc_sum[ACC_W];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    product_d   = product_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    if (!stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        product_d = prod_s;
        acc_d     = acc_sum[ACC_W-1:0];
        acc_ovf_d = (acc_ovf_q & ~s1_clr_q) | add_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mag_a_q  <= '0;
      s1_mag_b_q  <= '0;
      s1_neg_q    <= 1'b0;
      s1_sm_q     <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mag_a_q  <= s1_mag_a_d;
      s1_mag_b_q  <= s1_mag_b_d;
      s1_neg_q    <= s1_neg_d;
      s1_sm_q     <= s1_sm_d;
      s1_en_q     <= s1_en_d;
      s1_clr_q    <= s1_clr_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;
endmodule

// File: tb/tb_vedic_nxn_pipe.sv
// Bench for vedic_nxn_pipe (WIDTH=8, ACC_W=24): directed table, corner sequences,
// and random traffic against an arithmetic scoreboard.
module tb_vedic_nxn_pipe;
  localparam int W  = 8;
  localparam int AW = 24;
  localparam longint ACC_MOD = 64'd1 << AW;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, signed_mode, acc_en, acc_clr;
  logic out_valid, out_ready, acc_ovf;
  logic [W-1:0]    a, b;
  logic [2*W-1:0]  product;
  logic [AW-1:0]   acc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  a, b;
    logic        sm, en, clr;
    logic [15:0] p;
    logic [23:0] acc;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint m_acc = 0;
  logic   m_ovf = 1'b0;
  logic   took;

  always #5 clk = ~clk;

  vedic_nxn_pipe #(.WIDTH(W), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .acc(acc), .acc_ovf(acc_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product and accumulator arithmetic.
  task automatic model_push(input logic [7:0] xa, xb, input logic sm, en, clr);
    longint pa, pb, p, addend, base, s;
    logic ov;
    exp_t e;
    pa = sm ? longint'($signed(xa)) : longint'(xa);
    pb = sm ? longint'($signed(xb)) : longint'(xb);
    p  = pa * pb;
    e.p = p[15:0];
    addend = en ? (sm ? p : longint'(e.p)) : 0;
    base   = clr ? 0 : m_acc;
    if (sm) begin
      if (base >= ACC_MOD / 2) base = base - ACC_MOD;
      s  = base + addend;
      ov = (s > ACC_MOD / 2 - 1) || (s < -(ACC_MOD / 2));
    end else begin
      s  = base + addend;
      ov = (s >= ACC_MOD);
    end
    m_acc = s & (ACC_MOD - 1);
    m_ovf = (clr ? 1'b0 : m_ovf) | ov;
    e.acc = m_acc[23:0];
    e.ovf = m_ovf;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got output 0x%0h, want no output", product);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_product", product, mon_e.p);
          chk("sb_acc", acc, mon_e.acc);
          chk("sb_ovf", acc_ovf, mon_e.ovf);
        end
      end
      if (in_valid && in_ready) model_push(a, b, signed_mode, acc_en, acc_clr);
    end
  end

  always @(negedge rst_n) begin
    sb_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the transfer edge.
  task automatic send(input logic [7:0] xa, xb, input logic sm, en, clr);
    int n = 0;
    a = xa; b = xb; signed_mode = sm; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck at 0, want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    vec_t tbl[10];
    int n;
    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 16'hFE01, 24'h00FE01, 1'b0};
    tbl[1] = '{8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, 16'h0000, 24'h000000, 1'b0};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 16'h4000, 24'h004000, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 16'hFFFF, 24'hFFFFFF, 1'b0};
    tbl[4] = '{8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, 16'hC080, 24'hFFC080, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 16'hFE01, 24'h00FE01, 1'b0};
    tbl[6] = '{8'h64, 8'h64, 1'b0, 1'b1, 1'b1, 16'h2710, 24'h002710, 1'b0};
    tbl[7] = '{8'hC8, 8'hC8, 1'b0, 1'b1, 1'b0, 16'h9C40, 24'h00C350, 1'b0};
    tbl[8] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 16'hC080, 24'h00C350, 1'b0};
    tbl[9] = '{8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 16'h0009, 24'h000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_product", product, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", acc_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].en, tbl[i].clr);
      chk($sformatf("row%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), out_valid, 1);
      chk($sformatf("row%0d_product", i), product, tbl[i].p);
      chk($sformatf("row%0d_acc", i), acc, tbl[i].acc);
      chk($sformatf("row%0d_ovf", i), acc_ovf, tbl[i].ovf);
    end

    // Mixed modes back-to-back; each must use its own mode.
    send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_unsigned_product", product, 16'hFE01);
    @(negedge clk);

    // Backpressure with both stages full.
    out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    send(8'd4, 8'd5, 1'b0, 1'b0, 1'b0);
    a = 8'd6; b = 8'd7; in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp_hold%0d_product", k), product, 6);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_out0", product, 6);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_out1_valid", out_valid, 1);
    chk("bp_out1", product, 20);
    @(negedge clk);
    #1;
    chk("bp_out2_valid", out_valid, 1);
    chk("bp_out2", product, 42);
    @(negedge clk);
    #1;
    chk("bp_drained", out_valid, 0);
    @(negedge clk);

    // Unsigned accumulator overflow and sticky clear.
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k < 258; k++) send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovf258_acc", acc, 24'd16776450);
    chk("ovf258_flag", acc_ovf, 0);
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovf259_acc", acc, 24'd64259);
    chk("ovf259_flag", acc_ovf, 1);
    send(8'd3, 8'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovf_clr_acc", acc, 0);
    chk("ovf_clr_flag", acc_ovf, 0);

    // Random traffic with random backpressure.
    took = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        if ($urandom_range(0, 4) != 0) begin
          a = rnd_op(); b = rnd_op();
          signed_mode = 1'($urandom_range(0, 1));
          acc_en      = ($urandom_range(0, 3) != 0);
          acc_clr     = ($urandom_range(0, 15) == 0);
          in_valid    = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      took = in_valid && in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rand_drain_pending", sb_q.size(), 0);

    // Asynchronous reset with both stages full and output stalled.
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd5, 8'd5, 1'b0, 1'b1, 1'b1);
    send(8'd6, 8'd6, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst2_pre_in_ready", in_ready, 0);
    chk("rst2_pre_acc", acc, 25);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_acc", acc, 0);
    chk("rst2_product", product, 0);
    chk("rst2_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'd3, 8'd3, 1'b0, 1'b0, 1'b0);
    chk("rst2_early_valid", out_valid, 0);
    @(negedge clk);
    chk("rst2_valid", out_valid, 1);
    chk("rst2_product9", product, 9);
    chk("rst2_acc_after", acc, 0);
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
